dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the processor's load/store port: the far end of the controller's `MemRead`/`MemWrite`/`busy` handshake. It accepts one byte-wide read or write, holds `busy` high for a fixed, parameterised number of cycles to model a slow memory or cache, then completes the access. It sits beside the datapath and is driven by the controller's memory outputs and the datapath's address and store data. Its `busy` output feeds the controller's stall input (`PCPlus` does not advance while `busy`).

## Interface
- `NBITS`, 8: data and address width.
- `DEPTH`, 256: number of byte entries; index is `addr[$clog2(DEPTH)-1:0]`, upper address bits ignored.
- `LATENCY`, 3: cycles `busy` is high per access; legal range 1..15, checked by elaboration assertion.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `MemRead`  in  1  read request, level, held by the controller until completion.
- `MemWrite`  in  1  write request, level, held until completion.
- `addr`  in  NBITS  byte address.
- `WriteData`  in  NBITS  store data.
- `ReadData`  out  NBITS  load data, registered, valid from the completion cycle until the next read completes.
- `busy`  out  1  access in progress; the requester must stall.
- `proto_err`  out  1  sticky; requester violated the hold rule.

## Operation
- Reset: state=IDLE, `cnt`=0, `ReadData`=0, `busy`=0, `proto_err`=0. Array contents are not cleared.
- States:
  - IDLE: no access.
  - WAIT: counting down.
  - DONE: one completion cycle.
- IDLE:
  - If `MemRead|MemWrite`: accept.
    - Latch op, `addr` and `WriteData`.
    - `cnt`<=LATENCY-1.
    - Next state is WAIT if LATENCY>1, else DONE.
  - `busy` is high combinationally in the accept cycle.
- Simultaneous `MemRead` and `MemWrite`: treated as a write; `ReadData` is unchanged.
- WAIT:
  - `cnt`<=`cnt`-1.
  - When `cnt`==1, next state is DONE.
  - `busy`=1.
- Entering DONE, on the edge:
  - Write: array[latched index] <= latched data.
  - Read: `ReadData` <= array[latched index].
- DONE:
  - `busy`=0; the controller advances on this cycle's edge.
  - Next state is always IDLE, whatever the request inputs.
  - A request still visible in DONE is the completing one and is not re-accepted.
- Protocol check, in WAIT only: if the request drops, the op changes or `addr` differs from the latched value, set `proto_err`. The access still completes using the latched values. `proto_err` is cleared only by reset.
- Reset mid-access: the FSM aborts to IDLE immediately; a pending write is discarded.

## Timing
- Accept in cycle 0: `busy` is high in cycles 0..LATENCY-1 and low in cycle LATENCY (DONE).
- The next request can be accepted in cycle LATENCY+1.
- Back-to-back accesses have a throughput of one access per LATENCY+1 cycles.
- `busy` = (IDLE & (`MemRead`|`MemWrite`)) | WAIT. This is the only combinational path from input to output.
- `ReadData` and `proto_err` are pure flops.
- A read in DONE at cycle N shows the new `ReadData` in cycle N. A write completing at the same address in an earlier DONE is visible to any later read.

## Structure
- Package `dmem_pkg`:
  - `typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t`.
  - Constant `MAX_LATENCY`=15.
  - Counter width `$clog2(MAX_LATENCY+1)`.
- Sub-module `dmem_array`: synchronous-write, synchronous-read byte RAM (`DEPTH`×`NBITS`), with write enable and read enable. The FSM, counter, latches and checker live in `dmem_responder`.

## Test plan
- Reset, then idle inputs -> `busy`=0, `ReadData`=0x00 and `proto_err`=0 for 10 cycles.
- LATENCY=3: write 0x5A to 0x10 at cycle 0 -> `busy`=1 in cycles 0-2 and 0 in cycle 3. Then read 0x10 -> `ReadData`=0x5A in its DONE cycle.
- LATENCY=1: reads of 0x00, 0x01, 0x02 back to back after writing 0x11, 0x22, 0x33 -> each `busy` pulse is 1 cycle, and `ReadData` is 0x11, 0x22, 0x33 in successive DONE cycles, two cycles apart.
- `MemRead`=`MemWrite`=1, addr 0x20, data 0xC3 -> treated as a write; `ReadData` holds its previous value, and a later read of 0x20 returns 0xC3.
- Change `addr` 0x10->0x11 during WAIT -> `proto_err` rises next cycle and stays high; the write lands at 0x10, and 0x11 is unchanged.
- Assert `reset` during WAIT of a write of 0xFF to 0x30 -> `busy`=0 immediately and 0x30 keeps its old value. A request made the cycle after reset deasserts is accepted normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and limits for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/dmem_array.sv
// Byte RAM with synchronous write and a registered, resettable read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata
);

  logic [NBITS-1:0] mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Slow-memory responder for the load/store handshake: holds busy for LATENCY
// cycles per access, completes it in a one-cycle DONE state.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             busy,
  output logic             proto_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("dmem_responder: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
    end
  endgenerate

  dmem_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             lat_write;
  logic [NBITS-1:0] lat_addr;
  logic [NBITS-1:0] lat_data;

  logic             req;
  logic             accept;
  logic             enter_done;
  logic             cur_write;
  logic [NBITS-1:0] cur_addr;
  logic [NBITS-1:0] cur_data;
  logic             mem_we;
  logic             mem_re;

  assign req    = MemRead | MemWrite;
  assign accept = (state == IDLE) && req;
  assign busy   = accept || (state == WAIT);

  // With LATENCY=1 the access completes on the accept edge, before the
  // latches hold anything, so the array is fed from the live inputs then.
  assign enter_done = !reset &&
                      ((accept && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == CNT_W'(1))));
  assign cur_write  = (state == IDLE) ? MemWrite  : lat_write;
  assign cur_addr   = (state == IDLE) ? addr      : lat_addr;
  assign cur_data   = (state == IDLE) ? WriteData : lat_data;
  assign mem_we     = enter_done && cur_write;
  assign mem_re     = enter_done && !cur_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_write <= MemWrite;
            lat_addr  <= addr;
            lat_data  <= WriteData;
            cnt       <= CNT_INIT;
            state     <= (LATENCY > 1) ? WAIT : DONE;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flag: the requester must hold op and address steady while waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if ((state == WAIT) &&
                 (!req || (MemWrite != lat_write) || (addr != lat_addr))) begin
      proto_err <= 1'b1;
    end
  end

  dmem_array #(
    .NBITS (NBITS),
    .DEPTH (DEPTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (cur_addr[IDX_W-1:0]),
    .wdata (cur_data),
    .rdata (ReadData)
  );

endmodule
